// File: rtl/nt_stim_driver.sv
// LFSR-driven stimulus generator with a MISR compacting one DUT response bit.
// A LAT-deep valid pipeline aligns response sampling with the applied vectors.
//
// state | meaning
// IDLE  | waiting for start; signature and pass held from last run
// RUN   | one LFSR vector applied per cycle, nvec cycles
// DRAIN | LAT cycles for in-flight responses to be compacted
// DONE  | one-cycle done pulse, pass evaluated
module nt_stim_driver #(
    parameter int          LAT   = 2,
    parameter logic [15:0] ZSEED = 16'hACE1
) (
    input  logic        I1470,
    input  logic        I1477,
    input  logic        start,
    input  logic [15:0] seed,
    input  logic [15:0] nvec,
    input  logic [15:0] expect_sig,
    input  logic        resp,
    output logic [4:0]  stim,
    output logic        stim_valid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] sig
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [15:0] DRAIN_INIT = (LAT > 0) ? 16'(LAT - 1) : 16'd0;

    state_t      state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] misr_q, misr_d;
    logic        pass_q, pass_d;
    logic        sample_en;

    // x^16+x^14+x^13+x^11+1, shift toward MSB, feedback enters bit 0
    function automatic logic [15:0] step16(input logic [15:0] v, input logic in_bit);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10] ^ in_bit};
    endfunction

    generate
        if (LAT == 0) begin : g_nodl
            assign sample_en = stim_valid;
        end else begin : g_dl
            logic [LAT-1:0] dl_q, dl_d;

            always_comb begin
                dl_d    = dl_q << 1;
                dl_d[0] = stim_valid;
            end

            always_ff @(posedge I1470 or negedge I1477) begin
                if (!I1477) dl_q <= '0;
                else        dl_q <= dl_d;
            end

            assign sample_en = dl_q[LAT-1];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        misr_d  = misr_q;
        pass_d  = pass_q;

        if (sample_en) misr_d = step16(misr_q, resp);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    lfsr_d  = (seed == 16'd0) ? ZSEED : seed;
                    cnt_d   = nvec;
                    misr_d  = '0;
                    pass_d  = 1'b0;
                    state_d = (nvec == 16'd0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                lfsr_d = step16(lfsr_q, 1'b0);
                cnt_d  = cnt_q - 16'd1;
                if (cnt_q == 16'd1) begin
                    if (LAT == 0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = DRAIN_INIT;
                    end
                end
            end
            S_DRAIN: begin
                if (cnt_q == 16'd0) state_d = S_DONE;
                else                cnt_d   = cnt_q - 16'd1;
            end
            S_DONE: begin
                pass_d  = (misr_q == expect_sig);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I1470 or negedge I1477) begin
        if (!I1477) begin
            state_q <= S_IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            misr_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            misr_q  <= misr_d;
            pass_q  <= pass_d;
        end
    end

    assign stim       = lfsr_q[4:0];
    assign stim_valid = (state_q == S_RUN);
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign pass       = pass_q;
    assign sig        = misr_q;

endmodule
